// File: rtl/return_address_stack_if.sv
// Fetch-side strobes and predicted-return outputs of the return-address stack.
// The master modport is the fetch/predictor side; the slave modport is the stack itself.
interface return_address_stack_if;
    logic        push;
    logic        pop;
    logic [31:0] new_addr;
    logic        branch_fetched;
    logic        early_branch_flush_ras_adjust;
    logic        branch_retired;
    logic        branch_flush;
    logic        fetch_flush;
    logic [31:0] addr;
    logic        valid;

    modport master (
        output push, pop, new_addr, branch_fetched, early_branch_flush_ras_adjust,
               branch_retired, branch_flush, fetch_flush,
        input  addr, valid
    );

    modport slave (
        input  push, pop, new_addr, branch_fetched, early_branch_flush_ras_adjust,
               branch_retired, branch_flush, fetch_flush,
        output addr, valid
    );
endinterface

// File: rtl/return_address_stack.sv
// Speculative return-address stack with a FIFO of {read_index, count} checkpoints,
// one per in-flight predicted branch, used to undo speculative push/pop on a mispredict.
module return_address_stack #(
    parameter int DEPTH        = 8,
    parameter int BRANCH_TRACK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    return_address_stack_if.slave   ras
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BRANCH_TRACK);
    localparam int OW = $clog2(BRANCH_TRACK + 1);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
    } ckpt_t;

    logic [31:0]   stack_q [DEPTH];
    logic [31:0]   stack_d [DEPTH];
    ckpt_t         ckpt_q [BRANCH_TRACK];
    ckpt_t         ckpt_d [BRANCH_TRACK];
    logic [IW-1:0] read_index_q, read_index_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] head_q, head_d, tail_q, tail_d, head_ret;
    logic [OW-1:0] occ_q, occ_d, occ_ret;
    logic          flush;
    logic          enq_overflow;

    always_comb begin
        stack_d      = stack_q;
        ckpt_d       = ckpt_q;
        read_index_d = read_index_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        head_ret     = head_q;
        occ_ret      = occ_q;
        enq_overflow = 1'b0;
        flush        = ras.branch_flush | ras.fetch_flush;

        // Retirement happens first so a coincident mispredict restores from the next-oldest branch.
        if (ras.branch_retired && occ_q != '0) begin
            head_ret = head_q + 1'b1;
            occ_ret  = occ_q - 1'b1;
        end

        if (flush) begin
            if (ras.branch_flush && occ_ret != '0) begin
                read_index_d = ckpt_q[head_ret].idx;
                count_d      = ckpt_q[head_ret].cnt;
            end
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            head_d = head_ret;
            occ_d  = occ_ret;

            if (ras.push && ras.pop) begin
                stack_d[read_index_q] = ras.new_addr;
            end else if (ras.push) begin
                read_index_d          = read_index_q + 1'b1;
                stack_d[read_index_d] = ras.new_addr;
                count_d = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
            end else if (ras.pop && count_q != '0) begin
                read_index_d = read_index_q - 1'b1;
                count_d      = count_q - 1'b1;
            end

            // Dropping the youngest entry before enqueueing lets a coincident fetch replace it.
            if (ras.early_branch_flush_ras_adjust && occ_d != '0) begin
                tail_d = tail_q - 1'b1;
                occ_d  = occ_d - 1'b1;
            end
            if (ras.branch_fetched) begin
                enq_overflow   = (occ_d == OW'(BRANCH_TRACK));
                ckpt_d[tail_d] = {read_index_q, count_q};
                tail_d         = tail_d + 1'b1;
                occ_d          = occ_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_index_q <= '0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
        end else begin
            read_index_q <= read_index_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
        end
    end

    // Entry storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stack_q <= stack_d;
            ckpt_q  <= ckpt_d;
        end
    end

    assign ras.addr  = stack_q[read_index_q];
    assign ras.valid = (count_q != '0);

    no_ckpt_overflow: assert property (@(posedge clk) disable iff (rst) !enq_overflow);

endmodule
